// File: rtl/add_sub_arbiter_if.sv
// Bundles the two requester channels and the result channel of the
// add/sub arbiter so the design and its environment share one definition.
interface add_sub_arbiter_if;
  // Requester side
  logic        req0;
  logic        req1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        sna0;
  logic        sna1;
  logic        ack0;
  logic        ack1;

  // Result side
  logic [31:0] y;
  logic        co;
  logic        v;
  logic        z;
  logic        res_valid;
  logic        res_id;
  logic        res_ready;

  // Environment: drives requests and result acceptance
  modport master (
    output req0, req1, a0, b0, a1, b1, sna0, sna1, res_ready,
    input  ack0, ack1, y, co, v, z, res_valid, res_id
  );

  // Arbiter: consumes requests and produces results
  modport slave (
    input  req0, req1, a0, b0, a1, b1, sna0, sna1, res_ready,
    output ack0, ack1, y, co, v, z, res_valid, res_id
  );
endinterface

// File: rtl/add_sub_arbiter.sv
// Two-requester round-robin arbiter sharing a single 32-bit ripple-carry
// add/subtract unit. A request is captured in IDLE, the adder is given
// EXEC_CYCLES clocks to settle, and the result is held until accepted.

// 32-bit ripple-carry adder/subtractor: y = a + (b ^ {32{sna}}) + sna.
module rc_add_sub_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sna,
  output logic [31:0] y,
  output logic        co
);
  logic [31:0] b_eff;
  logic [32:0] carry;

  assign b_eff = b ^ {32{sna}};

  // Carry ripples from bit 0 upward; sna supplies the +1 of two's complement.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    carry    = '0;
    y        = '0;
    carry[0] = sna;
    for (int i = 0; i < 32; i++) begin
      y[i]         = a[i] ^ b_eff[i] ^ carry[i];
      carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
    co = carry[32];
  end
endmodule

module add_sub_arbiter #(
  parameter int unsigned EXEC_CYCLES = 2  // adder settle time, 1..15
) (
  input logic               clk,
  input logic               rst_n,
  add_sub_arbiter_if.slave  bus
);
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sna_r;
  logic        id_r;
  logic        last_gnt;

  logic        ack0_r;
  logic        ack1_r;
  logic [31:0] y_r;
  logic        co_r;
  logic        v_r;
  logic        z_r;
  logic        valid_r;
  logic        res_id_r;

  logic [31:0] sum;
  logic        sum_co;
  logic [31:0] b_eff;
  logic        ovf;
  logic        any_req;
  logic        grant_1;

  // The only adder instance; it sees nothing but the captured operands, so
  // requesters may change their inputs freely once acknowledged.
  rc_add_sub_32 u_adder (
    .a   (a_r),
    .b   (b_r),
    .sna (sna_r),
    .y   (sum),
    .co  (sum_co)
  );

  // Signed overflow: operands of equal sign producing a result of the other sign.
  assign b_eff = b_r ^ {32{sna_r}};
  assign ovf   = (a_r[31] == b_eff[31]) && (sum[31] != a_r[31]);

  // Round-robin pick: a lone request wins; on contention the requester that
  // was not granted last time wins.
  assign any_req = bus.req0 || bus.req1;
  assign grant_1 = bus.req1 && (!bus.req0 || !last_gnt);

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      sna_r    <= 1'b0;
      id_r     <= 1'b0;
      last_gnt <= 1'b1;  // requester 0 wins the first contention
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      y_r      <= '0;
      co_r     <= 1'b0;
      v_r      <= 1'b0;
      z_r      <= 1'b0;
      valid_r  <= 1'b0;
      res_id_r <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // pre-edge values, regardless of statement order.
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            a_r      <= grant_1 ? bus.a1   : bus.a0;
            b_r      <= grant_1 ? bus.b1   : bus.b0;
            sna_r    <= grant_1 ? bus.sna1 : bus.sna0;
            id_r     <= grant_1;
            last_gnt <= grant_1;
            ack0_r   <= !grant_1;
            ack1_r   <= grant_1;
            cnt      <= CNT_LOAD;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            y_r      <= sum;
            co_r     <= sum_co;
            v_r      <= ovf;
            z_r      <= (sum == 32'd0);
            valid_r  <= 1'b1;
            res_id_r <= id_r;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          // Requests are not looked at on the accepting edge; the next
          // capture happens one edge later from IDLE.
          if (bus.res_ready) begin
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack0_r;
  assign bus.ack1      = ack1_r;
  assign bus.y         = y_r;
  assign bus.co        = co_r;
  assign bus.v         = v_r;
  assign bus.z         = z_r;
  assign bus.res_valid = valid_r;
  assign bus.res_id    = res_id_r;
endmodule

// File: tb/tb_add_sub_arbiter.sv
// Self-checking bench for add_sub_arbiter: a transaction-level reference
// model compared every cycle, directed operations with literal results,
// contention, backpressure, mid-operation reset and randomized traffic.
module tb_add_sub_arbiter;
  localparam int E = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  add_sub_arbiter_if bus ();

  add_sub_arbiter #(.EXEC_CYCLES(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] y;
    logic        co;
    logic        v;
    logic        z;
    logic        id;
  } res_t;

  // Result from plain integer arithmetic on the operands.
  function automatic res_t golden(input logic id, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub);
    res_t   r;
    longint sa;
    longint sb;
    longint full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r.y  = a - b;
      r.co = (a >= b);
      full = sa - sb;
    end else begin
      {r.co, r.y} = {1'b0, a} + {1'b0, b};
      full = sa + sb;
    end
    r.v  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    r.z  = (r.y == 32'd0);
    r.id = id;
    return r;
  endfunction

  // Winner: the only requester, or on contention whoever was not granted last.
  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  res_t m_op;
  res_t m_res;
  logic m_busy;
  logic m_valid;
  logic m_ack0;
  logic m_ack1;
  logic m_last;
  int   m_edge;
  int   m_due;

  // Model: one operation at a time; result due E edges after capture,
  // held until accepted, next capture no sooner than the edge after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_op    <= '0;
      m_res   <= '0;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_ack0  <= 1'b0;
      m_ack1  <= 1'b0;
      m_last  <= 1'b1;
      m_edge  <= 0;
      m_due   <= 0;
    end else begin
      m_edge <= m_edge + 1;
      m_ack0 <= 1'b0;
      m_ack1 <= 1'b0;
      if (m_valid) begin
        if (bus.res_ready) begin
          m_valid <= 1'b0;
          m_busy  <= 1'b0;
        end
      end else if (m_busy) begin
        if (m_edge + 1 == m_due) begin
          m_valid <= 1'b1;
          m_res   <= m_op;
        end
      end else if (bus.req0 || bus.req1) begin
        if (pick(bus.req0, bus.req1, m_last)) begin
          m_op   <= golden(1'b1, bus.a1, bus.b1, bus.sna1);
          m_ack1 <= 1'b1;
        end else begin
          m_op   <= golden(1'b0, bus.a0, bus.b0, bus.sna0);
          m_ack0 <= 1'b1;
        end
        m_last <= pick(bus.req0, bus.req1, m_last);
        m_due  <= m_edge + 1 + E;
        m_busy <= 1'b1;
      end
    end
  end

  // Compare every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack0", 32'(bus.ack0), 32'(m_ack0));
      check("ack1", 32'(bus.ack1), 32'(m_ack1));
      check("res_valid", 32'(bus.res_valid), 32'(m_valid));
      check("y", bus.y, m_res.y);
      check("co", 32'(bus.co), 32'(m_res.co));
      check("v", 32'(bus.v), 32'(m_res.v));
      check("z", 32'(bus.z), 32'(m_res.z));
      check("res_id", 32'(bus.res_id), 32'(m_res.id));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 7));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack0"}, 32'(bus.ack0), 32'd0);
    check({tag, "_ack1"}, 32'(bus.ack1), 32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_y"}, bus.y, 32'd0);
    check({tag, "_co"}, 32'(bus.co), 32'd0);
    check({tag, "_v"}, 32'(bus.v), 32'd0);
    check({tag, "_z"}, 32'(bus.z), 32'd0);
    check({tag, "_res_id"}, 32'(bus.res_id), 32'd0);
  endtask

  // One directed operation with hand-computed expectations. Starts and ends on a negedge.
  task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic sub, input logic [31:0] ey,
                        input logic eco, input logic ev, input logic ez);
    int n;
    if (id) begin
      bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.sna1 = sub;
    end else begin
      bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.sna0 = sub;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? bus.ack1 : bus.ack0) && n < 50);
    check({tag, "_ack_seen"}, 32'(id ? bus.ack1 : bus.ack0), 32'd1);
    // Drop the request and disturb the operands; the result must not change.
    if (id) begin
      bus.req1 = 1'b0; bus.a1 = ~a; bus.b1 = b + 32'd1; bus.sna1 = ~sub;
    end else begin
      bus.req0 = 1'b0; bus.a0 = ~a; bus.b0 = b + 32'd1; bus.sna0 = ~sub;
    end
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_ack_one_cycle"}, 32'(id ? bus.ack1 : bus.ack0), 32'd0);
    end
    check({tag, "_latency"}, 32'(n), 32'(E));
    check({tag, "_y"}, bus.y, ey);
    check({tag, "_co"}, 32'(bus.co), 32'(eco));
    check({tag, "_v"}, 32'(bus.v), 32'(ev));
    check({tag, "_z"}, 32'(bus.z), 32'(ez));
    check({tag, "_res_id"}, 32'(bus.res_id), 32'(id));
    bus.res_ready = 1'b1;
    @(negedge clk);
    check({tag, "_accepted"}, 32'(bus.res_valid), 32'd0);
    bus.res_ready = 1'b0;
  endtask

  // Global time bound so the run always ends on its own.
  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int g_who[$];
    int g_cyc[$];

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.sna0 = 1'b0; bus.sna1 = 1'b0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Directed arithmetic with literal expectations
    run_op("add_5_3",   1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    run_op("sub_5_5",   1'b1, 32'd5, 32'd5, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_3_5",   1'b1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",   1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf",   1'b0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: result held while requester 1 waits
    bus.req0 = 1'b1; bus.a0 = 32'd10; bus.b0 = 32'd20; bus.sna0 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ack0 && n < 50);
    check("bp_ack0", 32'(bus.ack0), 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 32'd7; bus.b1 = 32'd2; bus.sna1 = 1'b1;
    n = 0;
    while (!bus.res_valid && n < 50) begin @(negedge clk); n++; end
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 32'(bus.res_valid), 32'd1);
      check("bp_y_held", bus.y, 32'd30);
      check("bp_no_ack1", 32'(bus.ack1), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_cleared", 32'(bus.res_valid), 32'd0);
    check("bp_no_ack1_on_accept", 32'(bus.ack1), 32'd0);
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("bp_ack1_after_accept", 32'(bus.ack1), 32'd1);
    bus.req1 = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_y1", bus.y, 32'd5);
    check("bp_co1", 32'(bus.co), 32'd1);
    check("bp_id1", 32'(bus.res_id), 32'd1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;

    // Reset one cycle after ACK0: operation abandoned
    bus.req0 = 1'b1; bus.a0 = 32'd1; bus.b0 = 32'd1; bus.sna0 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ack0 && n < 50);
    check("rst_ack0", 32'(bus.ack0), 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("rst_no_result", 32'(bus.res_valid), 32'd0);
    end

    // Contention from reset: alternating grants at the minimum period
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 32'd1;  bus.b0 = 32'd2; bus.sna0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 32'd10; bus.b1 = 32'd3; bus.sna1 = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (g_who.size() < 4 && n < 80) begin
      @(negedge clk);
      n++;
      check("cont_ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
      if (bus.ack0) begin g_who.push_back(0); g_cyc.push_back(n); end
      if (bus.ack1) begin g_who.push_back(1); g_cyc.push_back(n); end
    end
    check("cont_grants", 32'(g_who.size()), 32'd4);
    if (g_cyc.size() > 0) check("cont_first_capture", 32'(g_cyc[0]), 32'd1);
    foreach (g_who[i]) begin
      check("cont_order", 32'(g_who[i]), 32'(i % 2));
      if (i > 0) check("cont_period", 32'(g_cyc[i] - g_cyc[i-1]), 32'(E + 2));
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (E + 3) @(negedge clk);
    bus.res_ready = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!bus.req0 || bus.ack0) begin
        bus.req0 = ($urandom_range(0, 2) != 0);
        bus.a0 = rand_opnd(); bus.b0 = rand_opnd(); bus.sna0 = 1'($urandom_range(0, 1));
      end
      if (!bus.req1 || bus.ack1) begin
        bus.req1 = ($urandom_range(0, 2) != 0);
        bus.a1 = rand_opnd(); bus.b1 = rand_opnd(); bus.sna1 = 1'($urandom_range(0, 1));
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.res_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_idle", 32'(bus.res_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/add_sub_arbiter.md
ADD_SUB_ARBITER -- requirements
Module: add_sub_arbiter

Interface
REQ-001 Parameter: EXEC_CYCLES, 2, clock cycles allotted for the shared RC_ADD_SUB_32 instance to settle (legal range 1..15).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 REQ0, REQ1  input  1 each  request valid from requester 0/1; held high until the matching ACK.
REQ-005 A0, B0, A1, B1  input  32 each  operands of requester 0/1.
REQ-006 SNA0, SNA1  input  1 each  operation of requester 0/1 (0 = add, 1 = subtract A-B).
REQ-007 ACK0, ACK1  output  1 each  one-cycle pulse: operands of requester 0/1 captured.
REQ-008 Y  output  32  registered result.
REQ-009 CO  output  1  registered carry out of bit 31.
REQ-010 V  output  1  registered signed overflow.
REQ-011 Z  output  1  registered zero flag (Y == 0).
REQ-012 RES_VALID  output  1  result valid.
REQ-013 RES_ID  output  1  requester index owning the current result.
REQ-014 RES_READY  input  1  consumer accepts result when high together with RES_VALID at a rising edge.

Function
REQ-015 Block SHALL contain exactly one RC_ADD_SUB_32 instance, fed only from internal operand registers (A_R, B_R, SNA_R).
REQ-016 FSM states SHALL be IDLE, EXEC, HOLD.
REQ-017 IDLE: at an edge with any REQ high, SHALL capture the winner's A/B/SNA and index into registers, go to EXEC, load counter with EXEC_CYCLES-1.
REQ-018 Arbitration SHALL be round-robin: single request wins outright; if both are high, the requester not granted last wins; LAST_GNT updates on every capture.
REQ-019 ACKx SHALL be high for exactly the one cycle following the capture edge; the losing requester gets no ACK.
REQ-020 EXEC: counter SHALL decrement each edge; at the edge where counter == 0, Y/CO/V/Z SHALL latch from the adder, RES_VALID set, RES_ID = captured index, state -> HOLD.
REQ-021 Latency: RES_VALID SHALL rise exactly EXEC_CYCLES edges after the capture edge.
REQ-022 HOLD: Y, CO, V, Z, RES_ID SHALL stay stable while RES_VALID = 1 and RES_READY = 0.
REQ-023 HOLD: at an edge with RES_READY = 1, RES_VALID SHALL clear and state -> IDLE; no capture on that edge (minimum op period EXEC_CYCLES+2).
REQ-024 REQ inputs SHALL be ignored in EXEC and HOLD; a pending request waits without ACK.
REQ-025 A REQ still high in IDLE after its ACK SHALL be treated as a new request.
REQ-026 V SHALL equal (A_R[31] == Beff[31]) and (Y[31] != A_R[31]), where Beff = B_R xor {32{SNA_R}}.
REQ-027 CO SHALL be the raw adder carry (subtract: CO = 1 means no borrow).
REQ-028 Arithmetic SHALL be modulo 2^32; no saturation.
REQ-029 Operand changes after capture SHALL NOT affect the result in flight.

Reset
REQ-030 RST low SHALL immediately force: state IDLE, counter 0, ACK0 = ACK1 = 0, RES_VALID = 0, RES_ID = 0, Y = 0, CO = V = Z = 0, operand registers 0.
REQ-031 LAST_GNT SHALL reset to 1, so requester 0 wins the first simultaneous request.
REQ-032 Reset in EXEC or HOLD SHALL abandon the operation: no RES_VALID after release, no retry.
REQ-033 After RST rises, the first capture SHALL occur no earlier than the first rising edge with RST high.

Verification
REQ-034 Add: REQ0, A0 = 0x00000005, B0 = 0x00000003, SNA0 = 0, EXEC_CYCLES = 2 -> ACK0 one cycle after capture; RES_VALID 2 edges after capture; Y = 0x00000008, CO = 0, V = 0, Z = 0, RES_ID = 0.
REQ-035 Subtract: REQ1, A1 = 5, B1 = 5, SNA1 = 1 -> Y = 0, CO = 1, Z = 1, V = 0, RES_ID = 1; and A1 = 3, B1 = 5 -> Y = 0xFFFFFFFE, CO = 0.
REQ-036 Overflow: A0 = 0x7FFFFFFF, B0 = 1, add -> Y = 0x80000000, V = 1, CO = 0; A0 = 0x80000000, B0 = 1, subtract -> Y = 0x7FFFFFFF, V = 1, CO = 1.
REQ-037 Contention: REQ0 and REQ1 held high from reset, RES_READY = 1 -> grant order 0,1,0,1; each ACK exactly one cycle; period EXEC_CYCLES+2.
REQ-038 Backpressure: RES_READY = 0 for 5 cycles with REQ1 pending -> RES_VALID and Y stable, no ACK1; ACK1 follows the capture edge after the accepting handshake.
REQ-039 Reset mid-EXEC: RST low one cycle after ACK0 -> all outputs 0 asynchronously; after release RES_VALID stays 0 until a new REQ is captured.
